// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan encoder/decoder pair.
package seg7_pkg;

  // Active-low segment patterns, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] Seg0 = 7'h40;
  localparam logic [6:0] Seg1 = 7'h79;
  localparam logic [6:0] Seg2 = 7'h24;
  localparam logic [6:0] Seg3 = 7'h30;
  localparam logic [6:0] Seg4 = 7'h19;
  localparam logic [6:0] Seg5 = 7'h12;
  localparam logic [6:0] Seg6 = 7'h02;
  localparam logic [6:0] Seg7 = 7'h78;
  localparam logic [6:0] Seg8 = 7'h00;
  localparam logic [6:0] Seg9 = 7'h10;
  localparam logic [6:0] SegA = 7'h08;
  localparam logic [6:0] SegB = 7'h03;
  localparam logic [6:0] SegC = 7'h46;
  localparam logic [6:0] SegD = 7'h21;
  localparam logic [6:0] SegE = 7'h06;
  localparam logic [6:0] SegF = 7'h0E;

  typedef enum logic [1:0] {StIdle, StTrack, StCapt, StHold} seg7_state_e;

  // Returns {ok, nibble}; ok = 0 for any pattern outside the table (blank included).
  function automatic logic [4:0] seg_to_hex(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      Seg0:    res = {1'b1, 4'h0};
      Seg1:    res = {1'b1, 4'h1};
      Seg2:    res = {1'b1, 4'h2};
      Seg3:    res = {1'b1, 4'h3};
      Seg4:    res = {1'b1, 4'h4};
      Seg5:    res = {1'b1, 4'h5};
      Seg6:    res = {1'b1, 4'h6};
      Seg7:    res = {1'b1, 4'h7};
      Seg8:    res = {1'b1, 4'h8};
      Seg9:    res = {1'b1, 4'h9};
      SegA:    res = {1'b1, 4'hA};
      SegB:    res = {1'b1, 4'hB};
      SegC:    res = {1'b1, 4'hC};
      SegD:    res = {1'b1, 4'hD};
      SegE:    res = {1'b1, 4'hE};
      SegF:    res = {1'b1, 4'hF};
      default: res = 5'h00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Scan-bus bundle: display lines driven by the master, decode status returned by the slave.
interface seg7_scan_decoder_if;
  logic [6:0] SWG;
  logic       AN0;
  logic       AN1;
  logic [7:0] VALUE;
  logic       VALID;
  logic       CHANGED;
  logic       ERR;
  logic       STALE;

  modport master (output SWG, AN0, AN1, input VALUE, VALID, CHANGED, ERR, STALE);
  modport slave  (input SWG, AN0, AN1, output VALUE, VALID, CHANGED, ERR, STALE);
endinterface

// File: rtl/seg7_settle_tracker.sv
// Two-flop input stage plus settle FSM: emits one capture strobe per stable anode activation.
module seg7_settle_tracker
  import seg7_pkg::*;
#(
  parameter int unsigned SETTLE = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] swg_i,
  input  logic       an0_i,
  input  logic       an1_i,
  output logic       cap_o,
  output logic       cap_idx_o,
  output logic [6:0] cap_pat_o,
  output logic       clash_o
);

  localparam int unsigned CntW = $clog2(SETTLE + 1);
  localparam logic [CntW-1:0] SettleCnt = CntW'(SETTLE);

  logic [6:0] swg_meta_q, swg_meta_d, swg_s_q, swg_s_d;
  logic [1:0] an_meta_q, an_meta_d, an_s_q, an_s_d;  // {AN1, AN0}, active-low

  seg7_state_e     state_q, state_d;
  logic            idx_q, idx_d;
  logic [6:0]      pat_q, pat_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic both_act, one_act, act_idx;

  // Input synchroniser next-state.
  always_comb begin
    swg_meta_d = swg_i;
    swg_s_d    = swg_meta_q;
    an_meta_d  = {an1_i, an0_i};
    an_s_d     = an_meta_q;
  end

  assign both_act = (an_s_q == 2'b00);
  assign one_act  = an_s_q[0] ^ an_s_q[1];
  assign act_idx  = an_s_q[0];  // AN0 idle implies AN1 is the active one

  // Settle FSM: track a stable anode/pattern pair, strobe once, then hold until it moves.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    cap_o   = 1'b0;
    clash_o = 1'b0;
    if (both_act) begin
      clash_o = 1'b1;
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (one_act) begin
            idx_d   = act_idx;
            pat_d   = swg_s_q;
            cnt_d   = CntW'(1);
            state_d = (cnt_d >= SettleCnt) ? StCapt : StTrack;
          end
        end
        StTrack: begin
          if (!one_act) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (act_idx == idx_q && swg_s_q == pat_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d >= SettleCnt) state_d = StCapt;
          end else begin
            idx_d   = act_idx;
            pat_d   = swg_s_q;
            cnt_d   = CntW'(1);
            state_d = (cnt_d >= SettleCnt) ? StCapt : StTrack;
          end
        end
        StCapt: begin
          cap_o   = 1'b1;
          state_d = StHold;
        end
        StHold: begin
          if (!one_act) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (act_idx != idx_q || swg_s_q != pat_q) begin
            idx_d   = act_idx;
            pat_d   = swg_s_q;
            cnt_d   = CntW'(1);
            state_d = (cnt_d >= SettleCnt) ? StCapt : StTrack;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and synchroniser registers; reset parks the inputs at "all anodes off, blank".
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      swg_meta_q <= 7'h7F;
      swg_s_q    <= 7'h7F;
      an_meta_q  <= 2'b11;
      an_s_q     <= 2'b11;
      state_q    <= StIdle;
      idx_q      <= 1'b0;
      pat_q      <= 7'h7F;
      cnt_q      <= '0;
    end else begin
      swg_meta_q <= swg_meta_d;
      swg_s_q    <= swg_s_d;
      an_meta_q  <= an_meta_d;
      an_s_q     <= an_s_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      pat_q      <= pat_d;
      cnt_q      <= cnt_d;
    end
  end

  assign cap_idx_o = idx_q;
  assign cap_pat_o = pat_q;

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive-side scan decoder: assembles two settled digits into a byte and flags events.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input logic                 CLK,
  input logic                 RST_N,
  seg7_scan_decoder_if.slave  bus_io
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT);

  logic       cap, cap_idx, clash;
  logic [6:0] cap_pat;
  logic [4:0] dec;

  logic [1:0][3:0] dig_q, dig_d;
  logic [1:0]      got_q, got_d;
  logic [7:0]      value_q, value_d;
  logic            valid_q, valid_d, changed_q, changed_d, err_q, err_d;
  logic [TmoW-1:0] tmo_q, tmo_d;

  seg7_settle_tracker #(
    .SETTLE (SETTLE)
  ) u_tracker (
    .clk_i     (CLK),
    .rst_ni    (RST_N),
    .swg_i     (bus_io.SWG),
    .an0_i     (bus_io.AN0),
    .an1_i     (bus_io.AN1),
    .cap_o     (cap),
    .cap_idx_o (cap_idx),
    .cap_pat_o (cap_pat),
    .clash_o   (clash)
  );

  // Frame assembly: a frame completes in the capture cycle that fills the second digit.
  always_comb begin
    dec       = seg_to_hex(cap_pat);
    dig_d     = dig_q;
    got_d     = got_q;
    value_d   = value_q;
    valid_d   = 1'b0;
    changed_d = 1'b0;
    err_d     = clash | (cap & ~dec[4]);
    if (cap && dec[4]) begin
      dig_d[cap_idx] = dec[3:0];
      got_d[cap_idx] = 1'b1;
    end
    if (&got_d) begin
      value_d   = {dig_d[1], dig_d[0]};
      valid_d   = 1'b1;
      changed_d = (value_d != value_q);
      got_d     = '0;
    end
    if (valid_d)              tmo_d = '0;
    else if (tmo_q == TmoMax) tmo_d = tmo_q;
    else                      tmo_d = tmo_q + 1'b1;
  end

  // Output and frame registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      dig_q     <= '0;
      got_q     <= '0;
      value_q   <= 8'h00;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      dig_q     <= dig_d;
      got_q     <= got_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  assign bus_io.VALUE   = value_q;
  assign bus_io.VALID   = valid_q;
  assign bus_io.CHANGED = changed_q;
  assign bus_io.ERR     = err_q;
  assign bus_io.STALE   = (tmo_q == TmoMax);

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed plus randomized bench for seg7_scan_decoder against a run-level reference model.
module tb_seg7_scan_decoder;

  localparam int unsigned SETTLE  = 4;
  localparam int unsigned TIMEOUT = 16;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  seg7_scan_decoder_if bus ();

  seg7_scan_decoder #(
    .SETTLE  (SETTLE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .bus_io (bus)
  );

  always #5 CLK = ~CLK;

  // Hex digit 0..F to active-low segment pattern.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_cmp  = 0;
  int n_fail = 0;

  // Observed-event monitor.
  int   cyc = 0;
  int   obs_valid = 0, obs_changed = 0, obs_err = 0, obs_orphan = 0;
  int   valid_cyc = -1;
  logic stale_prev = 1'b0, stale_at_valid = 1'bx, stale_before_valid = 1'bx;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (bus.VALID === 1'b1) begin
      obs_valid          <= obs_valid + 1;
      valid_cyc          <= cyc;
      stale_at_valid     <= bus.STALE;
      stale_before_valid <= stale_prev;
      if (bus.CHANGED === 1'b1) obs_changed <= obs_changed + 1;
    end else if (bus.CHANGED === 1'b1) begin
      obs_orphan <= obs_orphan + 1;
    end
    if (bus.ERR === 1'b1) obs_err <= obs_err + 1;
    stale_prev <= bus.STALE;
  end

  // Reference model: one call per stimulus run of constant inputs.
  int         m_valid = 0, m_changed = 0, m_err = 0;
  logic [7:0] m_value = 8'h00;
  logic [3:0] m_dig [2];
  logic       m_got [2] = '{1'b0, 1'b0};
  int         run_start = 0;

  function automatic int decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (seg_tab[i] == p) return i;
    return -1;
  endfunction

  task automatic model_run(input logic a0, input logic a1, input logic [6:0] p, input int len);
    int d, idx;
    logic [7:0] nv;
    if (!a0 && !a1) begin
      m_err += len;
    end else if (a0 ^ a1) begin
      if (len >= int'(SETTLE)) begin
        idx = a0 ? 1 : 0;
        d   = decode(p);
        if (d < 0) begin
          m_err++;
        end else begin
          m_dig[idx] = d[3:0];
          m_got[idx] = 1'b1;
          if (m_got[0] && m_got[1]) begin
            nv = {m_dig[1], m_dig[0]};
            m_valid++;
            if (nv != m_value) m_changed++;
            m_value  = nv;
            m_got[0] = 1'b0;
            m_got[1] = 1'b0;
          end
        end
      end
    end
  endtask

  // Hold AN0/AN1/SWG for len clock cycles.
  task automatic run(input logic a0, input logic a1, input logic [6:0] p, input int len);
    @(negedge CLK);
    bus.AN0   = a0;
    bus.AN1   = a1;
    bus.SWG   = p;
    run_start = cyc;
    repeat (len - 1) @(negedge CLK);
    model_run(a0, a1, p, len);
  endtask

  task automatic idle(input int len);
    run(1'b1, 1'b1, 7'h7F, len);
  endtask

  task automatic do_reset(input int n);
    @(negedge CLK);
    RST_N = 1'b0;
    repeat (n) @(negedge CLK);
    bus.AN0  = 1'b1;
    bus.AN1  = 1'b1;
    bus.SWG  = 7'h7F;
    RST_N    = 1'b1;
    m_value  = 8'h00;
    m_got[0] = 1'b0;
    m_got[1] = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_counts(input string tag);
    #2;
    check({tag, "_valid_cnt"}, 32'(obs_valid), 32'(m_valid));
    check({tag, "_changed_cnt"}, 32'(obs_changed), 32'(m_changed));
    check({tag, "_err_cnt"}, 32'(obs_err), 32'(m_err));
    check({tag, "_value"}, 32'(bus.VALUE), 32'(m_value));
  endtask

  int t_last;

  initial begin
    bus.AN0 = 1'b1;
    bus.AN1 = 1'b1;
    bus.SWG = 7'h7F;

    // Reset state
    do_reset(5);
    #2;
    check("rst_value", 32'(bus.VALUE), 32'h00);
    check("rst_valid", 32'(bus.VALID), 32'h0);
    check("rst_changed", 32'(bus.CHANGED), 32'h0);
    check("rst_err", 32'(bus.ERR), 32'h0);
    check("rst_stale", 32'(bus.STALE), 32'h0);

    // Timeout boundary: STALE rises exactly TIMEOUT cycles after reset
    idle(TIMEOUT - 1);
    #2 check("stale_before_tmo", 32'(bus.STALE), 32'h0);
    idle(1);
    #2 check("stale_at_tmo", 32'(bus.STALE), 32'h1);
    idle(4);
    #2 check("stale_held", 32'(bus.STALE), 32'h1);
    run(1'b0, 1'b1, 7'h00, 8);
    idle(2);
    run(1'b1, 1'b0, 7'h30, 8);
    t_last = run_start;
    idle(8);
    check_counts("tmo_frame");
    check("tmo_frame_latency", 32'(valid_cyc), 32'(t_last + 3 + int'(SETTLE)));
    check("stale_before_valid", 32'(stale_before_valid), 32'h1);
    check("stale_at_valid", 32'(stale_at_valid), 32'h0);
    check("stale_after_frame", 32'(bus.STALE), 32'h0);

    // Basic frame 0x12, then an identical scan
    for (int rep = 0; rep < 2; rep++) begin
      run(1'b0, 1'b1, 7'h24, 8);
      idle(2);
      run(1'b1, 1'b0, 7'h79, 8);
      idle(8);
      check_counts(rep == 0 ? "basic_new" : "basic_repeat");
    end

    // Glitching pattern on one anode never settles
    for (int k = 0; k < 10; k++) run(1'b0, 1'b1, (k % 2 == 0) ? 7'h40 : 7'h79, 2);
    idle(8);
    check_counts("glitch");

    // Blank pattern is invalid; then a one-cycle anode clash
    run(1'b0, 1'b1, 7'h7F, 8);
    idle(8);
    check_counts("invalid_blank");
    run(1'b0, 1'b0, 7'h40, 1);
    idle(8);
    check_counts("clash");

    // High digit first, overwritten, then low digit
    run(1'b1, 1'b0, 7'h0E, 8);
    idle(2);
    run(1'b1, 1'b0, 7'h06, 8);
    idle(2);
    run(1'b0, 1'b1, 7'h03, 8);
    idle(8);
    check_counts("order_overwrite");

    // Reset mid-frame: half frame captured, TRACK in progress, then reset
    run(1'b1, 1'b0, 7'h46, 8);
    idle(2);
    run(1'b0, 1'b1, 7'h40, 3);
    do_reset(3);
    #2;
    check("midrst_value", 32'(bus.VALUE), 32'h00);
    check("midrst_valid", 32'(bus.VALID), 32'h0);
    check("midrst_err", 32'(bus.ERR), 32'h0);
    check("midrst_stale", 32'(bus.STALE), 32'h0);
    run(1'b0, 1'b1, 7'h79, 8);
    idle(8);
    check_counts("midrst_half");
    run(1'b1, 1'b0, 7'h24, 8);
    idle(8);
    check_counts("midrst_full");

    // Randomized runs: valid digits, invalid patterns, short glitches, clashes
    for (int it = 0; it < 40; it++) begin
      int         kind;
      int         len;
      logic       sel;
      logic [6:0] p;
      idle($urandom_range(1, 3));
      kind = $urandom_range(0, 9);
      sel  = 1'($urandom_range(0, 1));
      if (kind <= 5) begin
        p   = seg_tab[$urandom_range(0, 15)];
        len = $urandom_range(SETTLE + 1, SETTLE + 6);
        run(sel, ~sel, p, len);
      end else if (kind == 6) begin
        p = 7'($urandom_range(0, 127));
        while (decode(p) >= 0) p = 7'($urandom_range(0, 127));
        run(sel, ~sel, p, $urandom_range(SETTLE + 1, SETTLE + 4));
      end else if (kind == 7) begin
        p = 7'($urandom_range(0, 127));
        run(sel, ~sel, p, $urandom_range(1, SETTLE - 1));
      end else if (kind == 8) begin
        run(1'b0, 1'b0, 7'($urandom_range(0, 127)), $urandom_range(1, 2));
      end else begin
        idle(5);
      end
      if (it % 10 == 9) begin
        idle(8);
        check_counts("random");
      end
    end

    #2 check("orphan_changed", 32'(obs_orphan), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
